// File: rtl/apb5_regbank_pkg.sv
// Shared types for the APB5 register bank completer: security worlds,
// completer FSM states and the wait-state counter width.
// No ports; imported by apb5_regbank_decode and apb5_regbank_completer.
package apb5_regbank_pkg;

    localparam int WAIT_CNT_W = 4;

    // Encoding matches {pnse, pprot[1]} so the decode is a plain cast.
    typedef enum logic [1:0] {
        SECURE    = 2'b00,
        NONSECURE = 2'b01,
        ROOT      = 2'b10,
        REALM     = 2'b11
    } world_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic world_e world_decode(input logic nse, input logic prot1);
        return world_e'({nse, prot1});
    endfunction

    // Non-secure and Realm requesters may not touch Secure/Root-only registers.
    function automatic logic world_is_restricted(input world_e world);
        return (world == NONSECURE) || (world == REALM);
    endfunction

endpackage

// File: rtl/apb5_regbank_decode.sv
// Combinational register-index and error decode of a captured APB5 request.
// Ports: addr/write/strb/world in (captured request); idx, err out.
// Errors: index out of range, unaligned address, read with strobes, world violation.
import apb5_regbank_pkg::*;

module apb5_regbank_decode #(
    parameter int                  ADDR_WIDTH  = 12,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  IDX_W       = 3,
    parameter logic [NUM_REGS-1:0] SECURE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  world_e                  world,
    output logic [IDX_W-1:0]        idx,
    output logic                    err
);

    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    logic [ADDR_WIDTH-1:0] full_idx;
    logic                  out_of_range;
    logic                  unaligned;
    logic                  secure_hit;

    assign full_idx     = addr >> LSB;
    assign out_of_range = (full_idx >= ADDR_WIDTH'(NUM_REGS));
    assign unaligned    = |(addr & ALIGN_MASK);
    assign idx          = full_idx[IDX_W-1:0];
    // Only look up the mask for an in-range index; out-of-range already errors.
    assign secure_hit   = !out_of_range && SECURE_MASK[idx];

    assign err = out_of_range | unaligned | (!write && (|strb))
               | (secure_hit && world_is_restricted(world));

endmodule

// File: rtl/apb5_regbank_completer.sv
// APB5 (RME-aware) completer terminating in NUM_REGS read/write registers with
// programmable wait states, byte strobes and PSLVERR; registers exported on reg_q.
// Ports: APB5 completer signals (pclk/preset ... pbuser), reg_q, reg_wr_pulse.
// Optional macro APB5_REGBANK_USER_STORE_EN: per-register pwuser storage returned on pruser.
import apb5_regbank_pkg::*;

module apb5_regbank_completer #(
    parameter int                             ADDR_WIDTH      = 12,
    parameter int                             DATA_WIDTH      = 32,
    parameter int                             NUM_REGS        = 8,
    parameter int                             WAIT_STATES     = 0,
    parameter logic [NUM_REGS-1:0]            SECURE_MASK     = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int                             USER_REQ_WIDTH  = 4,
    parameter int                             USER_DATA_WIDTH = 4
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [2:0]                     pprot,
    input  logic                           pnse,
    input  logic                           pselx,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    input  logic [USER_REQ_WIDTH-1:0]      pauser,
    input  logic [USER_DATA_WIDTH-1:0]     pwuser,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [USER_DATA_WIDTH-1:0]     pruser,
    output logic [USER_REQ_WIDTH-1:0]      pbuser,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                    state;
    logic [WAIT_CNT_W-1:0]     cnt;

    logic [ADDR_WIDTH-1:0]     cap_addr;
    logic                      cap_write;
    logic [DATA_WIDTH-1:0]     cap_wdata;
    logic [STRB_W-1:0]         cap_strb;
    logic                      cap_nse;
    logic                      cap_prot1;
    logic [USER_REQ_WIDTH-1:0] cap_auser;

    logic [DATA_WIDTH-1:0]     regs [NUM_REGS];
    logic [IDX_W-1:0]          idx;
    logic                      err;
    logic                      wr_en;
    logic                      rd_ok;
    logic                      unused_ok;

    apb5_regbank_decode #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_REGS    (NUM_REGS),
        .IDX_W       (IDX_W),
        .SECURE_MASK (SECURE_MASK)
    ) u_decode (
        .addr  (cap_addr),
        .write (cap_write),
        .strb  (cap_strb),
        .world (world_decode(cap_nse, cap_prot1)),
        .idx   (idx),
        .err   (err)
    );

    // The completion cycle is the one where the registered pready is high;
    // the write lands on the edge that closes it.
    assign wr_en = (state == ACCESS) && pselx && pready && cap_write && !err;
    assign rd_ok = pready && !cap_write && !err;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            pready    <= 1'b0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            cap_nse   <= 1'b0;
            cap_prot1 <= 1'b0;
            cap_auser <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // penable without a setup phase is ignored here.
                    if (pselx && !penable) begin
                        cap_addr  <= paddr;
                        cap_write <= pwrite;
                        cap_wdata <= pwdata;
                        cap_strb  <= pstrb;
                        cap_nse   <= pnse;
                        cap_prot1 <= pprot[1];
                        cap_auser <= pauser;
                        cnt       <= WAIT_CNT_W'(WAIT_STATES);
                        pready    <= (WAIT_STATES == 0);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!pselx) begin
                        // Requester abandoned the transfer.
                        pready <= 1'b0;
                        state  <= IDLE;
                    end else if (pready) begin
                        pready <= 1'b0;
                        state  <= IDLE;
                    end else if (penable) begin
                        // pready is registered, so raise it as cnt moves to 0.
                        cnt    <= cnt - 1'b1;
                        pready <= (cnt == WAIT_CNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            reg_wr_pulse <= '0;
            if (wr_en) begin
                // Pulse even for an all-zero strobe: the write was still committed.
                reg_wr_pulse[idx] <= 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (cap_strb[b]) begin
                        regs[idx][b*8 +: 8] <= cap_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
    end

    assign prdata  = rd_ok ? regs[idx] : '0;
    assign pslverr = pready && err;
    assign pbuser  = pready ? cap_auser : '0;

`ifdef APB5_REGBANK_USER_STORE_EN
    logic [USER_DATA_WIDTH-1:0] cap_wuser;
    logic [USER_DATA_WIDTH-1:0] user_store [NUM_REGS];

    always_ff @(posedge pclk) begin
        if (preset) begin
            cap_wuser <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                user_store[i] <= '0;
            end
        end else begin
            if ((state == IDLE) && pselx && !penable) begin
                cap_wuser <= pwuser;
            end
            if (wr_en) begin
                user_store[idx] <= cap_wuser;
            end
        end
    end

    assign pruser    = rd_ok ? user_store[idx] : '0;
    assign unused_ok = ^{pprot[0], pprot[2]};
`else
    assign pruser    = '0;
    assign unused_ok = ^{pprot[0], pprot[2], pwuser};
`endif

endmodule

// File: tb/tb_apb5_regbank_completer.sv
// Directed self-checking bench: one 2-wait-state bank with a Secure register 0
// and one zero-wait bank share the APB request signals, each with its own select.
// Outputs are sampled at the falling edge or #1 after the rising edge.
module tb_apb5_regbank_completer;

    localparam logic [255:0] RV_A = 256'h0000_5A5A << 64;

    logic         pclk = 1'b0;
    logic         preset;
    logic [11:0]  paddr;
    logic [2:0]   pprot;
    logic         pnse;
    logic         psel_a, psel_b;
    logic         penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb, pauser, pwuser;

    logic         pready_a, pslverr_a, pready_b, pslverr_b;
    logic [31:0]  prdata_a, prdata_b;
    logic [3:0]   pruser_a, pbuser_a, pruser_b, pbuser_b;
    logic [255:0] reg_q_a, reg_q_b;
    logic [7:0]   pulse_a, pulse_b;

    int checks   = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb5_regbank_completer #(
        .WAIT_STATES (2), .SECURE_MASK (8'h01), .RESET_VALUE (RV_A)
    ) dut_a (
        .pclk (pclk), .preset (preset), .paddr (paddr), .pprot (pprot), .pnse (pnse),
        .pselx (psel_a), .penable (penable), .pwrite (pwrite), .pwdata (pwdata),
        .pstrb (pstrb), .pauser (pauser), .pwuser (pwuser), .pready (pready_a),
        .prdata (prdata_a), .pslverr (pslverr_a), .pruser (pruser_a), .pbuser (pbuser_a),
        .reg_q (reg_q_a), .reg_wr_pulse (pulse_a)
    );

    apb5_regbank_completer #(
        .WAIT_STATES (0)
    ) dut_b (
        .pclk (pclk), .preset (preset), .paddr (paddr), .pprot (pprot), .pnse (pnse),
        .pselx (psel_b), .penable (penable), .pwrite (pwrite), .pwdata (pwdata),
        .pstrb (pstrb), .pauser (pauser), .pwuser (pwuser), .pready (pready_b),
        .prdata (prdata_b), .pslverr (pslverr_b), .pruser (pruser_b), .pbuser (pbuser_b),
        .reg_q (reg_q_b), .reg_wr_pulse (pulse_b)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+#1; leaving right after the completion edge
    // lets a following call issue a back-to-back setup.
    task automatic xfer(input bit sel_b, input logic [11:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s, input logic nse,
                        input logic [2:0] prot, output logic [31:0] rd, output logic er,
                        output int n, output logic [7:0] pl, output logic [3:0] bu,
                        output logic [3:0] ru);
        bit done = 0;
        paddr = a; pwrite = w; pwdata = d; pstrb = s; pnse = nse; pprot = prot;
        pauser = 4'hA; pwuser = 4'h3; penable = 1'b0;
        if (sel_b) psel_b = 1'b1; else psel_a = 1'b1;
        rd = '0; er = 1'b0; bu = '0; ru = '0; n = 0;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge pclk);
            n++;
            if (sel_b ? pready_b : pready_a) begin
                rd = sel_b ? prdata_b : prdata_a;
                er = sel_b ? pslverr_b : pslverr_a;
                bu = sel_b ? pbuser_b : pbuser_a;
                ru = sel_b ? pruser_b : pruser_a;
                done = 1;
            end
            @(posedge pclk); #1;
        end
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
        pl = sel_b ? pulse_b : pulse_a;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;
        logic [7:0]  pl;
        logic [3:0]  bu, ru;
        logic [3:0]  exp_ru;
`ifdef APB5_REGBANK_USER_STORE_EN
        exp_ru = 4'h3;
`else
        exp_ru = 4'h0;
`endif
        preset = 1'b1; paddr = '0; pprot = '0; pnse = 1'b0; psel_a = 1'b0; psel_b = 1'b0;
        penable = 1'b0; pwrite = 1'b0; pwdata = '0; pstrb = '0; pauser = '0; pwuser = '0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_pready", pready_a, 1'b0);
        chk("rst_pslverr", pslverr_a, 1'b0);
        chk("rst_prdata", prdata_a, 32'h0);
        chk("rst_pbuser", pbuser_a, 4'h0);
        chk("rst_pulse", pulse_a, 8'h00);
        chk("rst_reg_q", reg_q_a, RV_A);
        preset = 1'b0;

        // Full write, Secure world: ready in the 3rd access cycle.
        xfer(0, 12'h004, 1, 32'hDEADBEEF, 4'hF, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("wr_cycles", n, 3);
        chk("wr_err", er, 1'b0);
        chk("wr_pbuser", bu, 4'hA);
        chk("wr_reg1", reg_q_a[63:32], 32'hDEADBEEF);
        chk("wr_pulse", pl, 8'h02);
        @(posedge pclk); #1;
        chk("wr_pulse_end", pulse_a, 8'h00);

        // Strobe write of bytes 0 and 2, then read back.
        xfer(0, 12'h004, 1, 32'h11223344, 4'h5, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("strb_err", er, 1'b0);
        xfer(0, 12'h004, 0, 32'h0, 4'h0, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("strb_rd", rd, 32'hDE22BE44);
        chk("strb_rd_err", er, 1'b0);
        chk("strb_rd_pruser", ru, exp_ru);
        chk("strb_rd_pulse", pl, 8'h00);

        // Decode errors.
        xfer(0, 12'h020, 0, 32'h0, 4'h0, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("oor_err", er, 1'b1);
        chk("oor_rd", rd, 32'h0);
        xfer(0, 12'h002, 1, 32'hFFFFFFFF, 4'hF, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("unal_err", er, 1'b1);
        chk("unal_pulse", pl, 8'h00);
        chk("unal_reg0", reg_q_a[31:0], 32'h0);
        xfer(0, 12'h004, 0, 32'h0, 4'h2, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("rdstrb_err", er, 1'b1);
        chk("rdstrb_rd", rd, 32'h0);

        // Secure register 0 from Non-secure, Realm, then Root.
        xfer(0, 12'h000, 1, 32'h0BADF00D, 4'hF, 0, 3'b010, rd, er, n, pl, bu, ru);
        chk("ns_err", er, 1'b1);
        chk("ns_pulse", pl, 8'h00);
        chk("ns_reg0", reg_q_a[31:0], 32'h0);
        xfer(0, 12'h000, 1, 32'h0BADF00D, 4'hF, 1, 3'b010, rd, er, n, pl, bu, ru);
        chk("realm_err", er, 1'b1);
        chk("realm_reg0", reg_q_a[31:0], 32'h0);
        xfer(0, 12'h000, 1, 32'h0BADF00D, 4'hF, 1, 3'b000, rd, er, n, pl, bu, ru);
        chk("root_err", er, 1'b0);
        chk("root_pulse", pl, 8'h01);
        chk("root_reg0", reg_q_a[31:0], 32'h0BADF00D);

        // Abandoned transfer: pselx drops in the first access cycle.
        paddr = 12'h010; pwrite = 1'b1; pwdata = 32'h55; pstrb = 4'hF; pnse = 1'b0;
        pprot = 3'b000; psel_a = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            chk("abort_pready", pready_a, 1'b0);
        end
        chk("abort_reg4", reg_q_a[159:128], 32'h0);
        chk("abort_pulse", pulse_a, 8'h00);
        @(posedge pclk); #1;

        // Zero-wait bank, back-to-back write then read.
        xfer(1, 12'h00C, 1, 32'h87654321, 4'hF, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("b2b_wr_cycles", n, 1);
        chk("b2b_wr_pulse", pl, 8'h08);
        xfer(1, 12'h00C, 0, 32'h0, 4'h0, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("b2b_rd_cycles", n, 1);
        chk("b2b_rd", rd, 32'h87654321);
        chk("b2b_rd_err", er, 1'b0);
        chk("b2b_reg3", reg_q_b[127:96], 32'h87654321);
        chk("b2b_quiet_a", reg_q_a[127:96], 32'h0);

        // Program register 2 on bank A, then reset in the 2nd access cycle of a write.
        xfer(0, 12'h008, 1, 32'hCAFEF00D, 4'hF, 0, 3'b000, rd, er, n, pl, bu, ru);
        chk("r2_reg2", reg_q_a[95:64], 32'hCAFEF00D);
        paddr = 12'h008; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
        psel_a = 1'b1; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(negedge pclk);
        chk("mid_rst_pready", pready_a, 1'b0);
        @(posedge pclk); #1;
        chk("mid_rst_reg_q", reg_q_a, RV_A);
        chk("mid_rst_pulse", pulse_a, 8'h00);
        preset = 1'b0;
        // pselx/penable still high with no setup: must be ignored.
        repeat (3) begin
            @(negedge pclk);
            chk("nosetup_pready", pready_a, 1'b0);
        end
        chk("nosetup_reg_q", reg_q_a, RV_A);
        @(posedge pclk); #1;
        psel_a = 1'b0; penable = 1'b0;
        repeat (2) @(posedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb5_regbank_completer.md
Name: apb5_regbank_completer

Overview:
- Parametrised APB5 (RME-aware) completer that terminates an APB5 interface in a bank of NUM_REGS read/write registers.
- Adds behaviour the bare interface definition does not provide:
  - programmable wait states;
  - byte-strobe writes;
  - PSLVERR generation for decode, alignment, strobe and security-world violations.
- Sits behind an APB5 bridge/decoder as the generic control-register block for peripherals.
- Drives register contents to the peripheral fabric as a flat vector.

Parameters:
- ADDR_WIDTH, 12, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32.
- NUM_REGS, 8, number of registers (1..256).
- WAIT_STATES, 0, extra access-phase cycles before pready (0..15).
- SECURE_MASK, '0, NUM_REGS bits; bit i=1 makes register i Secure/Root-only.
- RESET_VALUE, '0, NUM_REGS*DATA_WIDTH flat reset image.
- USER_REQ_WIDTH, 4, width of pauser/pbuser.
- USER_DATA_WIDTH, 4, width of pwuser/pruser.

Ports:
- pclk  in  1  APB clock.
- preset  in  1  synchronous, active-high reset.
- paddr  in  ADDR_WIDTH  address.
- pprot  in  3  protection.
- pnse  in  1  RME non-secure extension.
- pselx  in  1  select.
- penable  in  1  access phase.
- pwrite  in  1  1=write.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write strobes.
- pauser  in  USER_REQ_WIDTH  request user.
- pwuser  in  USER_DATA_WIDTH  write user.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  error response.
- pruser  out  USER_DATA_WIDTH  read user.
- pbuser  out  USER_REQ_WIDTH  response user.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse for each committed write.

Behaviour:
- Reset (preset=1 at a pclk edge):
  - state=IDLE;
  - pready, pslverr, prdata, pruser, pbuser, reg_wr_pulse = 0;
  - reg_q = RESET_VALUE.
- Reset mid-transfer aborts the transfer with no register update. Reset dominates all other events.
- FSM states:
  - IDLE: on pselx=1 and penable=0 (setup), capture paddr, pwrite, pwdata, pstrb, pprot, pnse, pauser, pwuser; load wait counter with WAIT_STATES; go to ACCESS.
  - IDLE: penable=1 without a preceding setup is ignored; pready stays 0.
  - ACCESS: counter decrements each cycle while pselx and penable are high. pready is registered and is 1 exactly in the cycle where the counter equals 0.
  - Access phase therefore lasts WAIT_STATES+1 cycles (WAIT_STATES=0: zero-wait).
  - Completion cycle (pready=1): transfer commits at the closing edge; next state is IDLE.
  - Back-to-back: a new setup in the cycle after completion is accepted normally. A transfer then needs a minimum of 2 cycles.
  - pselx dropping during ACCESS before pready abandons the transfer: return to IDLE with no update and no pulse.
- Decode, using the captured values:
  - idx = paddr >> log2(DATA_WIDTH/8).
  - Error conditions, any one of which causes an error:
    - (a) idx >= NUM_REGS;
    - (b) paddr low bits nonzero (unaligned);
    - (c) read with pstrb != 0;
    - (d) SECURE_MASK[idx]=1 and world is Non-secure ({pnse,pprot[1]}=01) or Realm (11).
  - Secure is 00 and Root is 10; both may access secure registers.
- Response:
  - pslverr=1 only in the pready=1 cycle of an erroring transfer.
  - Erroring writes change nothing and produce no pulse.
  - Erroring reads return prdata=0.
- Write commit: for each byte b with pstrb[b]=1, reg[idx] byte b <= pwdata byte b. reg_wr_pulse[idx]=1 for the cycle after commit, even when pstrb=0.
- Read: prdata=reg[idx] during the pready cycle. prdata, pruser and pbuser are 0 whenever pready=0.
- pbuser = captured pauser in the pready cycle.
- pwakeup is not consumed.
- pprot[0] and pprot[2] are ignored.

Optional Feature:
- Macro: APB5_REGBANK_USER_STORE_EN.
- Defined:
  - a per-register USER_DATA_WIDTH user field is written with pwuser on every committed write (reset 0);
  - reads return that field on pruser.
- Undefined:
  - no storage;
  - pruser is constant 0.

Decomposition:
- Package apb5_regbank_pkg holds:
  - world enum (SECURE, NONSECURE, ROOT, REALM) plus a world-decode function from {pnse,pprot[1]};
  - FSM state typedef (IDLE, ACCESS);
  - WAIT_CNT_W constant (4).
- One sub-module, apb5_regbank_decode: combinational idx/error decode from the captured request.
- FSM and storage stay in the top.

Test Plan (DATA_WIDTH=32, NUM_REGS=8, WAIT_STATES=2 unless noted):
- Write 0xDEADBEEF to 0x004, pstrb=0xF, Secure world:
  - pready high in the 3rd access cycle, pslverr=0;
  - reg_q[63:32]=0xDEADBEEF;
  - reg_wr_pulse=8'h02 for one cycle.
- Strobe write 0x11223344 with pstrb=0x5 to 0x004 (holding 0xDEADBEEF) -> read returns 0xDE22BE44.
- Read 0x020 (idx 8) -> pslverr=1, prdata=0. Write to 0x002 (unaligned) -> pslverr=1, no pulse.
- SECURE_MASK=8'h01:
  - Non-secure (pnse=0, pprot=3'b010) write to 0x000 -> pslverr=1, register unchanged;
  - same access from Root (pnse=1, pprot[1]=0) -> succeeds.
- WAIT_STATES=0 back-to-back write then read of 0x00C -> each completes in 2 cycles; read returns the written value.
- preset asserted in the 2nd access cycle of a write to 0x008 -> pready stays 0; reg_q returns to RESET_VALUE; no pulse.
